// File: rtl/uart_ctrl.sv
// Register-mapped sequencer for the uart core: TX/RX byte FIFOs, core handshakes, baud divisor.
// Optional interrupt output enabled by defining UART_CTRL_IRQ_EN.
module uart_ctrl #(
    parameter int          TX_DEPTH     = 4,
    parameter int          RX_DEPTH     = 4,
    parameter logic [11:0] BAUD_DEFAULT = 12'd104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  reg_addr,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [11:0] reg_wdata,
    output logic [11:0] reg_rdata,
    output logic        uart_start_tx,
    output logic [7:0]  uart_tx_value,
    input  logic        uart_tx_done,
    input  logic        uart_rx_available,
    input  logic [7:0]  uart_rx_value,
    output logic        uart_rx_clear,
    output logic [11:0] uart_counter_end
`ifdef UART_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW:0] TX_CNT_ONE = (TX_AW+1)'(1);
    localparam logic [RX_AW:0] RX_CNT_ONE = (RX_AW+1)'(1);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_BAUD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_WAIT = 3'd1;
    localparam logic [2:0] S_TX_REL  = 3'd2;
    localparam logic [2:0] S_RX_WAIT = 3'd3;
    localparam logic [2:0] S_RX_ACK  = 3'd4;

    logic [2:0]       state;
    logic             tx_pending;
    logic             ack_first;
    logic             tx_en;
    logic             rx_en;
    logic             overrun;
    logic             ie_rx;
    logic             ie_tx;
    logic [11:0]      baud;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_cnt;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_cnt;

    logic tx_full, tx_empty, rx_full, rx_empty, busy;
    logic data_wr, data_rd, ctrl_wr, baud_wr;
    logic tx_flush, rx_flush, clr_overrun;
    logic tx_push, tx_pop, rx_push, rx_push_ok, rx_pop, overrun_set;
    logic [11:0] rd_mux;

    assign tx_full  = (tx_cnt == TX_FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign busy     = (state != S_IDLE) | ~tx_empty;

    assign data_wr     = reg_wr & (reg_addr == ADDR_DATA);
    assign data_rd     = reg_rd & (reg_addr == ADDR_DATA);
    assign ctrl_wr     = reg_wr & (reg_addr == ADDR_CTRL);
    assign baud_wr     = reg_wr & (reg_addr == ADDR_BAUD) & ~busy;
    assign tx_flush    = ctrl_wr & reg_wdata[2];
    assign rx_flush    = ctrl_wr & reg_wdata[3];
    assign clr_overrun = ctrl_wr & reg_wdata[4];

    // A pending (preempted) byte always goes out before anything new is popped.
    assign tx_pop      = (state == S_IDLE) & ~uart_rx_available & ~tx_pending & tx_en
                         & ~tx_empty & ~tx_flush;
    assign tx_push     = data_wr & (~tx_full | tx_pop);
    assign rx_pop      = data_rd & ~rx_empty;
    assign rx_push     = (state == S_RX_ACK) & ack_first;
    assign rx_push_ok  = rx_push & (~rx_full | rx_pop);
    assign overrun_set = rx_push & rx_full & ~rx_pop;

    assign uart_rx_clear    = ((state == S_IDLE) & ~rx_en) | (state == S_RX_ACK);
    assign uart_counter_end = baud;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= reg_wdata[7:0];
        if (rx_push_ok)
            rx_mem[rx_wr_ptr] <= uart_rx_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + TX_PTR_ONE;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + TX_PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + TX_CNT_ONE;
                2'b01:   tx_cnt <= tx_cnt - TX_CNT_ONE;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push_ok)
                rx_wr_ptr <= rx_wr_ptr + RX_PTR_ONE;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + RX_PTR_ONE;
            case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + RX_CNT_ONE;
                2'b01:   rx_cnt <= rx_cnt - RX_CNT_ONE;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_en   <= 1'b1;
            rx_en   <= 1'b1;
            overrun <= 1'b0;
            baud    <= BAUD_DEFAULT;
        end else begin
            if (ctrl_wr) begin
                tx_en <= reg_wdata[0];
                rx_en <= reg_wdata[1];
            end
            if (baud_wr)
                baud <= reg_wdata;
            if (overrun_set)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

`ifdef UART_CTRL_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_rx <= 1'b0;
            ie_tx <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ie_rx <= reg_wdata[5];
                ie_tx <= reg_wdata[6];
            end
            irq <= (ie_rx & (~rx_empty | overrun)) | (ie_tx & tx_empty & (state == S_IDLE));
        end
    end
`else
    assign ie_rx = 1'b0;
    assign ie_tx = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_DATA:   if (!rx_empty) rd_mux = {4'h0, rx_mem[rx_rd_ptr]};
            ADDR_STATUS: rd_mux = {6'b0, busy, overrun, rx_full, ~rx_empty, tx_empty, tx_full};
            ADDR_BAUD:   rd_mux = baud;
            ADDR_CTRL:   rd_mux = {5'b0, ie_tx, ie_rx, 3'b0, rx_en, tx_en};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            reg_rdata <= '0;
        else if (reg_rd)
            reg_rdata <= rd_mux;
    end

    // Core handshake sequencer; RX is always serviced ahead of TX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            uart_start_tx <= 1'b0;
            uart_tx_value <= '0;
            tx_pending    <= 1'b0;
            ack_first     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (uart_rx_available) begin
                        state <= S_RX_WAIT;
                    end else if (tx_pending) begin
                        uart_start_tx <= 1'b1;
                        state         <= S_TX_WAIT;
                    end else if (tx_pop) begin
                        uart_tx_value <= tx_mem[tx_rd_ptr];
                        uart_start_tx <= 1'b1;
                        tx_pending    <= 1'b1;
                        state         <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (uart_tx_done) begin
                        uart_start_tx <= 1'b0;
                        tx_pending    <= 1'b0;
                        state         <= S_TX_REL;
                    end else if (uart_rx_available) begin
                        uart_start_tx <= 1'b0;
                        state         <= S_RX_WAIT;
                    end
                end
                S_TX_REL: begin
                    if (!uart_tx_done)
                        state <= S_IDLE;
                end
                S_RX_WAIT: begin
                    ack_first <= 1'b1;
                    state     <= S_RX_ACK;
                end
                S_RX_ACK: begin
                    ack_first <= 1'b0;
                    if (!uart_rx_available)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
